// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - run/pause/lap/clear controller with BCD SS.cc counter
module stopwatch_ctrl #(
    parameter int TICKS_PER_CS = 10,
    parameter int SEC_MAX      = 59
) (
    input  logic        clk_100M,
    input  logic        rst_n,
    input  logic        tick_1k,
    input  logic        btn_start_stop,
    input  logic        btn_lap_clr,
    output logic [15:0] disp_bcd,
    output logic        running,
    output logic        lap_active,
    output logic        wrap
);

    localparam int PW = (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;
    localparam logic [3:0] SEC_T = 4'(SEC_MAX / 10);
    localparam logic [3:0] SEC_U = 4'(SEC_MAX % 10);

    typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [15:0]   count, count_nxt;
    logic [15:0]   lap_latch, lap_latch_nxt;
    logic [15:0]   disp_nxt;
    logic          wrap_nxt, running_nxt, lap_active_nxt;
    logic          at_max;
    logic [3:0]    cu, ct, su, st;

    always_ff @(posedge clk_100M) begin
        if (!rst_n) begin
            state      <= IDLE;
            presc      <= '0;
            count      <= '0;
            lap_latch  <= '0;
            disp_bcd   <= '0;
            running    <= 1'b0;
            lap_active <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            state      <= state_nxt;
            presc      <= presc_nxt;
            count      <= count_nxt;
            lap_latch  <= lap_latch_nxt;
            disp_bcd   <= disp_nxt;
            running    <= running_nxt;
            lap_active <= lap_active_nxt;
            wrap       <= wrap_nxt;
        end
    end

    // start_stop wins over lap_clr when both pulse in the same cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (btn_start_stop) state_nxt = RUN;
            RUN:     if (btn_start_stop) state_nxt = PAUSE;
                     else if (btn_lap_clr) state_nxt = LAP;
            LAP:     if (btn_start_stop) state_nxt = PAUSE;
                     else if (btn_lap_clr) state_nxt = RUN;
            PAUSE:   if (btn_start_stop) state_nxt = RUN;
                     else if (btn_lap_clr) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign at_max = (count[15:12] == SEC_T) && (count[11:8] == SEC_U) && (count[7:0] == 8'h99);

    always_comb begin
        presc_nxt     = presc;
        count_nxt     = count;
        lap_latch_nxt = lap_latch;
        wrap_nxt      = 1'b0;
        st = count[15:12];
        su = count[11:8];
        ct = count[7:4];
        cu = count[3:0];

        if ((state == RUN || state == LAP) && tick_1k) begin
            if (presc == PW'(TICKS_PER_CS - 1)) begin
                presc_nxt = '0;
                if (at_max) begin
                    count_nxt = '0;
                    wrap_nxt  = 1'b1;
                end else begin
                    if (cu != 4'd9) cu = cu + 4'd1;
                    else begin
                        cu = 4'd0;
                        if (ct != 4'd9) ct = ct + 4'd1;
                        else begin
                            ct = 4'd0;
                            if (su != 4'd9) su = su + 4'd1;
                            else begin
                                su = 4'd0;
                                st = st + 4'd1;
                            end
                        end
                    end
                    count_nxt = {st, su, ct, cu};
                end
            end else begin
                presc_nxt = presc + PW'(1);
            end
        end

        // lap captures the pre-tick count of this cycle
        if (state == RUN && !btn_start_stop && btn_lap_clr)
            lap_latch_nxt = count;

        if (state == PAUSE && !btn_start_stop && btn_lap_clr) begin
            presc_nxt     = '0;
            count_nxt     = '0;
            lap_latch_nxt = '0;
        end
    end

    always_comb begin
        disp_nxt       = (state_nxt == LAP) ? lap_latch_nxt : count_nxt;
        running_nxt    = (state_nxt == RUN) || (state_nxt == LAP);
        lap_active_nxt = (state_nxt == LAP);
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed table and sequence bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

    logic        clk_100M = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_1k = 1'b0;
    logic        btn_start_stop = 1'b0;
    logic        btn_lap_clr = 1'b0;
    logic [15:0] disp_bcd;
    logic        running, lap_active, wrap;

    int pass_cnt = 0;
    int total_cnt = 0;
    int wrap_cnt = 0;
    int bad_digit = 0;
    int run_drop = 0;

    typedef struct {
        int          pre;
        logic        tk;
        logic        ss;
        logic        lc;
        logic [15:0] disp;
        logic        run;
        logic        lap;
    } vec_t;

    vec_t vecs[14];

    stopwatch_ctrl dut (
        .clk_100M       (clk_100M),
        .rst_n          (rst_n),
        .tick_1k        (tick_1k),
        .btn_start_stop (btn_start_stop),
        .btn_lap_clr    (btn_lap_clr),
        .disp_bcd       (disp_bcd),
        .running        (running),
        .lap_active     (lap_active),
        .wrap           (wrap)
    );

    always #5 clk_100M = ~clk_100M;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic observe();
        if (disp_bcd[3:0] > 4'd9 || disp_bcd[7:4] > 4'd9 ||
            disp_bcd[11:8] > 4'd9 || disp_bcd[15:12] > 4'd9) bad_digit++;
        if (wrap) wrap_cnt++;
        if (!running) run_drop++;
    endtask

    task automatic cycle(input logic tk, input logic ss, input logic lc);
        tick_1k = tk;
        btn_start_stop = ss;
        btn_lap_clr = lc;
        @(posedge clk_100M);
        #1;
        tick_1k = 1'b0;
        btn_start_stop = 1'b0;
        btn_lap_clr = 1'b0;
        observe();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick_1k = 1'b1;
            btn_start_stop = i[0];
            btn_lap_clr = ~i[0];
            @(posedge clk_100M);
            #1;
        end
        tick_1k = 1'b0;
        btn_start_stop = 1'b0;
        btn_lap_clr = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{9, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0};
        vecs[3]  = '{0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1};
        vecs[4]  = '{20, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b1};
        vecs[5]  = '{0, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b0};
        vecs[6]  = '{0, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b0, 1'b0};
        vecs[7]  = '{30, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0};
        vecs[8]  = '{0, 1'b0, 1'b1, 1'b0, 16'h0003, 1'b1, 1'b0};
        vecs[9]  = '{9, 1'b1, 1'b1, 1'b0, 16'h0004, 1'b0, 1'b0};
        vecs[10] = '{0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[11] = '{0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[12] = '{5, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1};
        vecs[13] = '{4, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};

        // T1 reset
        do_reset();
        check("rst_disp", disp_bcd, 16'h0000);
        check("rst_running", running, 1'b0);
        check("rst_lap", lap_active, 1'b0);
        check("rst_wrap", wrap, 1'b0);

        // transition table
        wrap_cnt = 0;
        for (int v = 0; v < 14; v++) begin
            ticks(vecs[v].pre);
            cycle(vecs[v].tk, vecs[v].ss, vecs[v].lc);
            check($sformatf("vec%0d_disp", v), disp_bcd, vecs[v].disp);
            check($sformatf("vec%0d_running", v), running, vecs[v].run);
            check($sformatf("vec%0d_lap", v), lap_active, vecs[v].lap);
        end
        check("vec_no_wrap", wrap_cnt, 0);

        // T2 / T3 count and wrap
        do_reset();
        bad_digit = 0;
        wrap_cnt = 0;
        cycle(1'b0, 1'b1, 1'b0);
        ticks(10);
        check("cnt_0001", disp_bcd, 16'h0001);
        ticks(990);
        check("cnt_0100", disp_bcd, 16'h0100);
        ticks(58990);
        check("cnt_5999", disp_bcd, 16'h5999);
        ticks(9);
        check("cnt_5999_hold", disp_bcd, 16'h5999);
        check("wrap_early", wrap_cnt, 0);
        ticks(1);
        check("wrap_disp", disp_bcd, 16'h0000);
        check("wrap_pulse", wrap, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        check("wrap_one_cycle", wrap, 1'b0);
        check("wrap_count", wrap_cnt, 1);
        check("bcd_digits", bad_digit, 0);

        // T4 lap
        do_reset();
        cycle(1'b0, 1'b1, 1'b0);
        ticks(2500);
        check("lap_pre", disp_bcd, 16'h0250);
        run_drop = 0;
        cycle(1'b0, 1'b0, 1'b1);
        check("lap_enter", lap_active, 1'b1);
        ticks(200);
        check("lap_frozen", disp_bcd, 16'h0250);
        cycle(1'b0, 1'b0, 1'b1);
        check("lap_exit_disp", disp_bcd, 16'h0270);
        check("lap_exit_flag", lap_active, 1'b0);
        check("lap_running", run_drop, 0);

        // T5 pause / clear
        do_reset();
        cycle(1'b0, 1'b1, 1'b0);
        ticks(1235);
        check("pause_pre", disp_bcd, 16'h0123);
        cycle(1'b0, 1'b1, 1'b0);
        check("pause_running", running, 1'b0);
        ticks(500);
        check("pause_hold", disp_bcd, 16'h0123);
        cycle(1'b0, 1'b0, 1'b1);
        check("clear_disp", disp_bcd, 16'h0000);
        cycle(1'b0, 1'b0, 1'b1);
        check("idle_lc_disp", disp_bcd, 16'h0000);
        check("idle_lc_running", running, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        ticks(9);
        check("clear_presc", disp_bcd, 16'h0000);
        ticks(1);
        check("clear_presc_cs", disp_bcd, 16'h0001);

        // T6 reset during LAP
        do_reset();
        cycle(1'b0, 1'b1, 1'b0);
        ticks(30);
        cycle(1'b0, 1'b0, 1'b1);
        check("lap6_flag", lap_active, 1'b1);
        rst_n = 1'b0;
        cycle(1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        check("lap_rst_disp", disp_bcd, 16'h0000);
        check("lap_rst_running", running, 1'b0);
        check("lap_rst_lap", lap_active, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        ticks(10);
        check("post_rst_count", disp_bcd, 16'h0001);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
